// File: rtl/be_pkg.sv
// ---------------------------------------------------------------------------
// be_pkg
// Shared definitions for the back-end EX->MEM->WB plumbing.
//   WB_SEL_*  : bit positions inside the one-hot write-back source select
//   DEF_*     : default lane count and datapath / register-address widths
//   mem_entry_t : one MEM pipeline register entry at the default widths
// ---------------------------------------------------------------------------
package be_pkg;

   // One-hot write-back source select bit positions
   localparam int WB_SEL_ALU  = 0;
   localparam int WB_SEL_LD   = 1;
   localparam int WB_SEL_MUL  = 2;
   localparam int WB_SEL_MULH = 3;
   localparam int WB_SEL_DIV  = 4;
   localparam int WB_SEL_MOD  = 5;
   localparam int WB_SEL_W    = WB_SEL_MOD + 1;

   // Default geometry
   localparam int DEF_LANES = 2;
   localparam int DEF_XLEN  = 32;
   localparam int DEF_RA_W  = 5;
   localparam int DEF_NSRC  = 2;

   typedef struct packed {
      logic                valid;
      logic                we;
      logic [DEF_RA_W-1:0] waddr;
      logic [DEF_XLEN-1:0] alu_result;
      logic [WB_SEL_W-1:0] wb_sel;
   } mem_entry_t;

endpackage

// File: rtl/be_fwd_mux.sv
// ---------------------------------------------------------------------------
// be_fwd_mux
// Operand bypass for a single EX source. Picks the youngest in-flight
// producer of raddr_i: MEM lanes (highest index first), then WB lanes
// (highest index first), else the register-file read data.
//   raddr_i / rdata_i   : EX source address and RF read data
//   mem_we_i            : MEM lane will write the RF
//   mem_waddr_i         : MEM lane destination registers
//   mem_alu_i           : MEM lane ALU results (the only MEM-stage bypass value)
//   mem_is_alu_i        : MEM lane write-back source is the ALU
//   wb_we_i / wb_waddr_i / wb_wdata_i : WB lane write port
//   rdata_o             : forwarded operand
//   hazard_o            : winning producer is in MEM with a non-ALU result
// ---------------------------------------------------------------------------
module be_fwd_mux
   import be_pkg::*;
#(
   parameter int LANES = DEF_LANES,
   parameter int XLEN  = DEF_XLEN,
   parameter int RA_W  = DEF_RA_W
) (
   input  logic [RA_W-1:0]       raddr_i,
   input  logic [XLEN-1:0]       rdata_i,
   input  logic [LANES-1:0]      mem_we_i,
   input  logic [LANES*RA_W-1:0] mem_waddr_i,
   input  logic [LANES*XLEN-1:0] mem_alu_i,
   input  logic [LANES-1:0]      mem_is_alu_i,
   input  logic [LANES-1:0]      wb_we_i,
   input  logic [LANES*RA_W-1:0] wb_waddr_i,
   input  logic [LANES*XLEN-1:0] wb_wdata_i,
   output logic [XLEN-1:0]       rdata_o,
   output logic                  hazard_o
);

   // NOTE: every output of an always_comb gets a default first; a path that
   // leaves one unassigned would infer a latch.
   always_comb begin
      rdata_o  = rdata_i;
      hazard_o = 1'b0;
      if (raddr_i != '0) begin
         // Ascending scans where later hits overwrite earlier ones, so the
         // highest lane wins; the MEM scan runs last so MEM beats WB.
         for (int j = 0; j < LANES; j++) begin
            if (wb_we_i[j] && (wb_waddr_i[j*RA_W +: RA_W] == raddr_i)) begin
               rdata_o = wb_wdata_i[j*XLEN +: XLEN];
            end
         end
         for (int j = 0; j < LANES; j++) begin
            if (mem_we_i[j] && (mem_waddr_i[j*RA_W +: RA_W] == raddr_i)) begin
               rdata_o  = mem_alu_i[j*XLEN +: XLEN];
               hazard_o = ~mem_is_alu_i[j];
            end
         end
      end
   end

endmodule

// File: rtl/be_pipe_fwd.sv
// ---------------------------------------------------------------------------
// be_pipe_fwd
// MEM and WB pipeline registers for LANES issue lanes, with write-back source
// selection, MEM/WB operand forwarding, branch-kill / flush squashing, stall
// freeze, and load-use detection with bubble insertion.
//   clk, rstn          : clock, asynchronous active-low reset
//   ex_*               : EX-stage lane group (valid, RF write, sources, kill)
//   flush_i / stall_i  : squash the EX group / freeze MEM and WB
//   mem_src_data       : MEM-stage results for select bits 1..SEL_W-1
//   ex_rf_rdata_f      : forwarded EX source operands
//   ld_use_stall       : EX must hold, MEM receives a bubble
//   wb_*               : register-file write port, one per lane
// ---------------------------------------------------------------------------
module be_pipe_fwd
   import be_pkg::*;
#(
   parameter int LANES = DEF_LANES,
   parameter int XLEN  = DEF_XLEN,
   parameter int RA_W  = DEF_RA_W,
   parameter int NSRC  = DEF_NSRC,
   parameter int SEL_W = WB_SEL_W
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic [LANES-1:0]            ex_valid,
   input  logic [LANES-1:0]            ex_rf_we,
   input  logic [LANES*RA_W-1:0]       ex_rf_waddr,
   input  logic [LANES*XLEN-1:0]       ex_alu_result,
   input  logic [LANES*SEL_W-1:0]      ex_wb_sel,
   input  logic [LANES-1:0]            ex_br_kill,
   input  logic [LANES*NSRC*RA_W-1:0]  ex_rf_raddr,
   input  logic [LANES*NSRC*XLEN-1:0]  ex_rf_rdata,
   input  logic                        flush_i,
   input  logic                        stall_i,
   input  logic [(SEL_W-1)*XLEN-1:0]   mem_src_data,
   output logic [LANES*NSRC*XLEN-1:0]  ex_rf_rdata_f,
   output logic                        ld_use_stall,
   output logic [LANES-1:0]            wb_valid,
   output logic [LANES-1:0]            wb_rf_we,
   output logic [LANES*RA_W-1:0]       wb_rf_waddr,
   output logic [LANES*XLEN-1:0]       wb_rf_wdata
);

   typedef struct packed {
      logic             valid;
      logic             we;
      logic [RA_W-1:0]  waddr;
      logic [XLEN-1:0]  alu_result;
      logic [SEL_W-1:0] wb_sel;
   } mem_lane_t;

   mem_lane_t [LANES-1:0] mem_q, mem_d;

   logic [LANES-1:0]      wb_valid_q, wb_valid_d;
   logic [LANES-1:0]      wb_we_q,    wb_we_d;
   logic [LANES*RA_W-1:0] wb_waddr_q, wb_waddr_d;
   logic [LANES*XLEN-1:0] wb_wdata_q, wb_wdata_d;

   logic [LANES-1:0]      kill;
   logic [LANES-1:0]      mem_we, mem_is_alu;
   logic [LANES*RA_W-1:0] mem_waddr;
   logic [LANES*XLEN-1:0] mem_alu;
   logic [LANES*NSRC-1:0] op_hazard;
   logic                  ld_use;

   // A mispredict in lane i squashes only the younger lanes after it.
   always_comb begin
      logic acc;
      acc  = flush_i;
      kill = '0;
      for (int j = 0; j < LANES; j++) begin
         kill[j] = acc;
         acc     = acc | ex_br_kill[j];
      end
   end

   // ------------------------------------------------------------------
   // Forwarding: one priority mux per EX source operand
   // ------------------------------------------------------------------
   for (genvar j = 0; j < LANES; j++) begin : g_lane
      assign mem_we[j]                   = mem_q[j].we;
      assign mem_is_alu[j]               = mem_q[j].wb_sel[WB_SEL_ALU];
      assign mem_waddr[j*RA_W +: RA_W]   = mem_q[j].waddr;
      assign mem_alu[j*XLEN +: XLEN]     = mem_q[j].alu_result;

      for (genvar s = 0; s < NSRC; s++) begin : g_src
         localparam int OP = j*NSRC + s;

         be_fwd_mux #(
            .LANES (LANES),
            .XLEN  (XLEN),
            .RA_W  (RA_W)
         ) u_fwd (
            .raddr_i      (ex_rf_raddr[OP*RA_W +: RA_W]),
            .rdata_i      (ex_rf_rdata[OP*XLEN +: XLEN]),
            .mem_we_i     (mem_we),
            .mem_waddr_i  (mem_waddr),
            .mem_alu_i    (mem_alu),
            .mem_is_alu_i (mem_is_alu),
            .wb_we_i      (wb_we_q),
            .wb_waddr_i   (wb_waddr_q),
            .wb_wdata_i   (wb_wdata_q),
            .rdata_o      (ex_rf_rdata_f[OP*XLEN +: XLEN]),
            .hazard_o     (op_hazard[OP])
         );
      end
   end

   // A hazard only matters for a live, unsquashed EX lane.
   always_comb begin
      ld_use = 1'b0;
      for (int j = 0; j < LANES; j++) begin
         for (int s = 0; s < NSRC; s++) begin
            if (ex_valid[j] && !kill[j] && op_hazard[j*NSRC + s]) begin
               ld_use = 1'b1;
            end
         end
      end
   end

   assign ld_use_stall = ld_use;

   // ------------------------------------------------------------------
   // MEM admission: squashed or bubbled lanes enter as all-zero entries
   // ------------------------------------------------------------------
   always_comb begin
      mem_d = '0;
      for (int j = 0; j < LANES; j++) begin
         if (ex_valid[j] && !kill[j] && !ld_use) begin
            mem_d[j].valid      = 1'b1;
            mem_d[j].we         = ex_rf_we[j] && (ex_rf_waddr[j*RA_W +: RA_W] != '0);
            mem_d[j].waddr      = ex_rf_waddr[j*RA_W +: RA_W];
            mem_d[j].alu_result = ex_alu_result[j*XLEN +: XLEN];
            mem_d[j].wb_sel     = ex_wb_sel[j*SEL_W +: SEL_W];
         end
      end
   end

   // ------------------------------------------------------------------
   // MEM -> WB: AND-OR one-hot select; an all-zero select yields zero
   // ------------------------------------------------------------------
   always_comb begin
      logic [XLEN-1:0] wd;
      wb_valid_d = '0;
      wb_we_d    = '0;
      wb_waddr_d = '0;
      wb_wdata_d = '0;
      for (int j = 0; j < LANES; j++) begin
         wd = '0;
         if (mem_q[j].wb_sel[WB_SEL_ALU]) begin
            wd = mem_q[j].alu_result;
         end
         for (int k = 1; k < SEL_W; k++) begin
            if (mem_q[j].wb_sel[k]) begin
               wd = wd | mem_src_data[(k-1)*XLEN +: XLEN];
            end
         end
         wb_valid_d[j]                = mem_q[j].valid;
         wb_we_d[j]                   = mem_q[j].we;
         wb_waddr_d[j*RA_W +: RA_W]   = mem_q[j].waddr;
         wb_wdata_d[j*XLEN +: XLEN]   = wd;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   // Stall freezes both stages and overrides kill, flush and bubble insertion.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mem_q      <= '0;
         wb_valid_q <= '0;
         wb_we_q    <= '0;
         wb_waddr_q <= '0;
         wb_wdata_q <= '0;
      end else if (!stall_i) begin
         mem_q      <= mem_d;
         wb_valid_q <= wb_valid_d;
         wb_we_q    <= wb_we_d;
         wb_waddr_q <= wb_waddr_d;
         wb_wdata_q <= wb_wdata_d;
      end
   end

   assign wb_valid    = wb_valid_q;
   assign wb_rf_we    = wb_we_q;
   assign wb_rf_waddr = wb_waddr_q;
   assign wb_rf_wdata = wb_wdata_q;

endmodule

// File: tb/tb_be_pipe_fwd.sv
// ---------------------------------------------------------------------------
// tb_be_pipe_fwd
// Four-lane bench for be_pipe_fwd. A reference model tracks the in-flight
// MEM and WB groups; expected WB contents are queued each cycle and a
// separate monitor pops and compares whenever the DUT shows a valid WB lane.
// Forwarded operands and ld_use_stall are compared combinationally.
// ---------------------------------------------------------------------------
module tb_be_pipe_fwd;

   localparam int L     = 4;
   localparam int XLEN  = 32;
   localparam int RA_W  = 5;
   localparam int NSRC  = 2;
   localparam int SEL_W = 6;
   localparam logic [SEL_W-1:0] SEL_ALU = 6'b000001;
   localparam logic [SEL_W-1:0] SEL_LD  = 6'b000010;

   logic                       clk = 1'b0;
   logic                       rstn;
   logic [L-1:0]               ex_valid, ex_rf_we, ex_br_kill;
   logic [L*RA_W-1:0]          ex_rf_waddr;
   logic [L*XLEN-1:0]          ex_alu_result;
   logic [L*SEL_W-1:0]         ex_wb_sel;
   logic [L*NSRC*RA_W-1:0]     ex_rf_raddr;
   logic [L*NSRC*XLEN-1:0]     ex_rf_rdata;
   logic                       flush_i, stall_i;
   logic [(SEL_W-1)*XLEN-1:0]  mem_src_data;
   logic [L*NSRC*XLEN-1:0]     ex_rf_rdata_f;
   logic                       ld_use_stall;
   logic [L-1:0]               wb_valid, wb_rf_we;
   logic [L*RA_W-1:0]          wb_rf_waddr;
   logic [L*XLEN-1:0]          wb_rf_wdata;

   always #5 clk = ~clk;

   be_pipe_fwd #(
      .LANES (L),
      .XLEN  (XLEN),
      .RA_W  (RA_W),
      .NSRC  (NSRC),
      .SEL_W (SEL_W)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .ex_valid      (ex_valid),
      .ex_rf_we      (ex_rf_we),
      .ex_rf_waddr   (ex_rf_waddr),
      .ex_alu_result (ex_alu_result),
      .ex_wb_sel     (ex_wb_sel),
      .ex_br_kill    (ex_br_kill),
      .ex_rf_raddr   (ex_rf_raddr),
      .ex_rf_rdata   (ex_rf_rdata),
      .flush_i       (flush_i),
      .stall_i       (stall_i),
      .mem_src_data  (mem_src_data),
      .ex_rf_rdata_f (ex_rf_rdata_f),
      .ld_use_stall  (ld_use_stall),
      .wb_valid      (wb_valid),
      .wb_rf_we      (wb_rf_we),
      .wb_rf_waddr   (wb_rf_waddr),
      .wb_rf_wdata   (wb_rf_wdata)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: contents of the two in-flight groups
   // ------------------------------------------------------------------
   logic [L-1:0]     m_v, m_we, w_v, w_we;
   logic [RA_W-1:0]  m_wa [L];
   logic [XLEN-1:0]  m_alu [L];
   logic [SEL_W-1:0] m_sel [L];
   logic [RA_W-1:0]  w_wa [L];
   logic [XLEN-1:0]  w_wd [L];
   logic             exp_lus;

   typedef struct packed {
      logic [L-1:0]      v;
      logic [L-1:0]      we;
      logic [L*RA_W-1:0] wa;
      logic [L*XLEN-1:0] wd;
   } wb_exp_t;

   wb_exp_t sb[$];
   bit      mon_en = 1'b1;

   task automatic model_clear();
      m_v = '0; m_we = '0; w_v = '0; w_we = '0;
      for (int j = 0; j < L; j++) begin
         m_wa[j] = '0; m_alu[j] = '0; m_sel[j] = '0; w_wa[j] = '0; w_wd[j] = '0;
      end
   endtask

   function automatic logic lane_killed(input int j);
      logic [L-1:0] older;
      older = (L'(1) << j) - L'(1);
      return flush_i | (|(ex_br_kill & older));
   endfunction

   // Youngest in-flight writer of r wins; a MEM hit only offers the ALU value.
   function automatic void model_fwd(input logic [RA_W-1:0] r, input logic [XLEN-1:0] rd,
                                     output logic [XLEN-1:0] d, output logic hz);
      d  = rd;
      hz = 1'b0;
      if (r == '0) return;
      for (int j = L-1; j >= 0; j--) begin
         if (m_we[j] && m_wa[j] == r) begin
            d  = m_alu[j];
            hz = !m_sel[j][0];
            return;
         end
      end
      for (int j = L-1; j >= 0; j--) begin
         if (w_we[j] && w_wa[j] == r) begin
            d = w_wd[j];
            return;
         end
      end
   endfunction

   function automatic logic [XLEN-1:0] src_val(input int k);
      return mem_src_data[k*XLEN +: XLEN];
   endfunction

   function automatic logic [XLEN-1:0] fwd_out(input int j, input int s);
      return ex_rf_rdata_f[(j*NSRC+s)*XLEN +: XLEN];
   endfunction

   // Let the inputs settle, then compare the combinational outputs.
   task automatic eval();
      logic [XLEN-1:0] d;
      logic            hz;
      #1;
      exp_lus = 1'b0;
      for (int j = 0; j < L; j++) begin
         for (int s = 0; s < NSRC; s++) begin
            model_fwd(ex_rf_raddr[(j*NSRC+s)*RA_W +: RA_W],
                      ex_rf_rdata[(j*NSRC+s)*XLEN +: XLEN], d, hz);
            check($sformatf("fwd_l%0d_s%0d", j, s), fwd_out(j, s), d);
            if (ex_valid[j] && !lane_killed(j) && hz) exp_lus = 1'b1;
         end
      end
      check("ld_use_stall", ld_use_stall, exp_lus);
   endtask

   // Advance the model across the coming clock edge and queue the WB state.
   task automatic adv();
      wb_exp_t e;
      logic    adm;
      if (!stall_i) begin
         w_v  = m_v;
         w_we = m_we;
         for (int j = 0; j < L; j++) begin
            w_wa[j] = m_wa[j];
            w_wd[j] = '0;
            for (int k = 0; k < SEL_W; k++) begin
               if (m_sel[j][k]) w_wd[j] = w_wd[j] | ((k == 0) ? m_alu[j] : src_val(k-1));
            end
         end
         for (int j = 0; j < L; j++) begin
            adm      = ex_valid[j] && !lane_killed(j) && !exp_lus;
            m_v[j]   = adm;
            m_we[j]  = adm && ex_rf_we[j] && (ex_rf_waddr[j*RA_W +: RA_W] != '0);
            m_wa[j]  = ex_rf_waddr[j*RA_W +: RA_W];
            m_alu[j] = ex_alu_result[j*XLEN +: XLEN];
            m_sel[j] = adm ? ex_wb_sel[j*SEL_W +: SEL_W] : '0;
         end
      end
      if (|w_v) begin
         e.v  = w_v;
         e.we = w_we;
         for (int j = 0; j < L; j++) begin
            e.wa[j*RA_W +: RA_W] = w_wa[j];
            e.wd[j*XLEN +: XLEN] = w_wd[j];
         end
         sb.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic step();
      eval();
      adv();
   endtask

   // ------------------------------------------------------------------
   // Monitor: compare WB whenever any lane is presented
   // ------------------------------------------------------------------
   initial begin
      wb_exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (mon_en && rstn && (|wb_valid)) begin
            if (sb.size() == 0) begin
               check("wb_unexpected_valid", wb_valid, '0);
            end else begin
               e = sb.pop_front();
               check("wb_valid", wb_valid, e.v);
               check("wb_rf_we", wb_rf_we, e.we);
               for (int j = 0; j < L; j++) begin
                  if (e.v[j]) begin
                     check($sformatf("wb_waddr_l%0d", j), wb_rf_waddr[j*RA_W +: RA_W], e.wa[j*RA_W +: RA_W]);
                     check($sformatf("wb_wdata_l%0d", j), wb_rf_wdata[j*XLEN +: XLEN], e.wd[j*XLEN +: XLEN]);
                  end
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic clr_ex();
      ex_valid = '0; ex_rf_we = '0; ex_br_kill = '0;
      ex_rf_waddr = '0; ex_alu_result = '0; ex_wb_sel = '0; ex_rf_raddr = '0;
      flush_i = 1'b0; stall_i = 1'b0;
      for (int i = 0; i < L*NSRC; i++) ex_rf_rdata[i*XLEN +: XLEN] = $urandom;
      for (int k = 0; k < SEL_W-1; k++) mem_src_data[k*XLEN +: XLEN] = $urandom;
   endtask

   task automatic set_wr(input int j, input logic we, input logic [RA_W-1:0] wa,
                         input logic [XLEN-1:0] alu, input logic [SEL_W-1:0] sel);
      ex_valid[j] = 1'b1;
      ex_rf_we[j] = we;
      ex_rf_waddr[j*RA_W +: RA_W]     = wa;
      ex_alu_result[j*XLEN +: XLEN]   = alu;
      ex_wb_sel[j*SEL_W +: SEL_W]     = sel;
   endtask

   task automatic set_rd(input int j, input int s, input logic [RA_W-1:0] ra);
      ex_valid[j] = 1'b1;
      ex_rf_raddr[(j*NSRC+s)*RA_W +: RA_W] = ra;
   endtask

   task automatic rand_group();
      int sp;
      clr_ex();
      ex_valid = L'($urandom);
      ex_rf_we = L'($urandom);
      for (int j = 0; j < L; j++) begin
         ex_rf_waddr[j*RA_W +: RA_W]   = RA_W'($urandom_range(0, 7));
         ex_alu_result[j*XLEN +: XLEN] = $urandom;
         ex_wb_sel[j*SEL_W +: SEL_W]   = SEL_ALU;
      end
      // At most one lane per group takes a non-ALU source.
      sp = $urandom_range(0, L-1);
      if ($urandom_range(0, 9) < 3)
         ex_wb_sel[sp*SEL_W +: SEL_W] = SEL_W'(1) << $urandom_range(1, SEL_W-1);
      else if ($urandom_range(0, 19) == 0)
         ex_wb_sel[sp*SEL_W +: SEL_W] = '0;
      for (int i = 0; i < L*NSRC; i++) ex_rf_raddr[i*RA_W +: RA_W] = RA_W'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) ex_br_kill = L'($urandom);
      flush_i = ($urandom_range(0, 11) == 0);
      stall_i = ($urandom_range(0, 5) == 0);
   endtask

   // ------------------------------------------------------------------
   // Test sequence
   // ------------------------------------------------------------------
   initial begin
      model_clear();
      clr_ex();
      rstn = 1'b0;
      #12;
      check("rst_wb_valid", wb_valid, '0);
      check("rst_wb_rf_we", wb_rf_we, '0);
      check("rst_wb_waddr", wb_rf_waddr, '0);
      check("rst_wb_wdata", wb_rf_wdata, '0);
      check("rst_ld_use", ld_use_stall, 1'b0);
      @(negedge clk);
      rstn = 1'b1;

      // Back-to-back dependency through MEM then WB
      clr_ex(); set_wr(0, 1, 5, 32'h11, SEL_ALU); step();
      clr_ex(); set_rd(1, 0, 5); eval();
      check("b2b_mem_fwd", fwd_out(1, 0), 32'h11); adv();
      clr_ex(); set_rd(0, 0, 5); eval();
      check("b2b_wb_fwd", fwd_out(0, 0), 32'h11);
      check("b2b_wb_we0", wb_rf_we[0], 1'b1);
      check("b2b_wb_waddr0", wb_rf_waddr[RA_W-1:0], 5);
      adv();
      clr_ex(); step(); clr_ex(); step();

      // Priority: youngest MEM lane beats older MEM lane and WB
      clr_ex(); set_wr(0, 1, 2, 32'h1, SEL_ALU); set_wr(1, 1, 7, 32'hC, SEL_ALU); step();
      clr_ex(); set_wr(0, 1, 7, 32'hA, SEL_ALU); set_wr(1, 1, 7, 32'hB, SEL_ALU); step();
      clr_ex(); set_rd(2, 1, 7); eval();
      check("prio_r7", fwd_out(2, 1), 32'hB); adv();
      clr_ex(); step(); clr_ex(); step();

      // Load-use: one bubble, then the load value arrives through WB
      clr_ex(); set_wr(1, 1, 3, 32'h77, SEL_LD); step();
      clr_ex(); set_rd(0, 0, 3); eval();
      check("lu_stall", ld_use_stall, 1'b1);
      mem_src_data[XLEN-1:0] = 32'hDEAD;
      adv();
      eval();
      check("lu_clear", ld_use_stall, 1'b0);
      check("lu_wb_fwd", fwd_out(0, 0), 32'hDEAD);
      adv();
      clr_ex(); step(); clr_ex(); step();

      // Branch kill squashes younger lanes only
      clr_ex();
      for (int j = 0; j < L; j++) set_wr(j, 1, RA_W'(j+1), XLEN'(j*16+1), SEL_ALU);
      ex_br_kill = 4'b0010; step();
      clr_ex(); step();
      clr_ex(); eval(); check("kill_wb_valid", wb_valid, 4'b0011); adv();

      // Flush squashes the whole group
      clr_ex();
      for (int j = 0; j < L; j++) set_wr(j, 1, RA_W'(j+1), XLEN'(j+100), SEL_ALU);
      flush_i = 1'b1; step();
      clr_ex(); step();
      clr_ex(); eval(); check("flush_wb_valid", wb_valid, 4'b0000); adv();

      // Writes to r0 never reach the RF; reads of r0 bypass nothing
      clr_ex(); set_wr(0, 1, 0, 32'h99, SEL_ALU); step();
      clr_ex(); step();
      clr_ex(); set_rd(1, 0, 0); eval();
      check("r0_wb_valid", wb_valid[0], 1'b1);
      check("r0_wb_we", wb_rf_we[0], 1'b0);
      check("r0_read", fwd_out(1, 0), ex_rf_rdata[(1*NSRC+0)*XLEN +: XLEN]);
      adv();

      // Stall freezes WB, ignores flush, and does not absorb EX
      clr_ex(); set_wr(0, 1, 9, 32'h55, SEL_ALU); step();
      clr_ex(); step();
      clr_ex(); set_wr(1, 1, 10, 32'h66, SEL_ALU);
      for (int c = 0; c < 3; c++) begin
         stall_i = 1'b1;
         flush_i = (c == 1);
         eval();
         check("stall_waddr", wb_rf_waddr[RA_W-1:0], 9);
         check("stall_wdata", wb_rf_wdata[XLEN-1:0], 32'h55);
         check("stall_we", wb_rf_we[0], 1'b1);
         adv();
      end
      stall_i = 1'b0; flush_i = 1'b0; step();
      clr_ex(); step();
      clr_ex(); eval();
      check("resume_waddr1", wb_rf_waddr[2*RA_W-1:RA_W], 10);
      check("resume_wdata1", wb_rf_wdata[2*XLEN-1:XLEN], 32'h66);
      adv();

      // Randomised traffic
      for (int c = 0; c < 400; c++) begin
         rand_group();
         step();
      end
      for (int c = 0; c < 3; c++) begin
         clr_ex(); step();
      end
      check("sb_drained", sb.size(), 0);

      // Asynchronous reset in the middle of a stall with a pending load-use
      clr_ex(); set_wr(0, 1, 12, 32'h12, SEL_ALU); step();
      clr_ex(); set_wr(0, 1, 4, 32'h44, SEL_LD); step();
      clr_ex(); set_rd(1, 0, 4); stall_i = 1'b1; eval();
      check("pre_rst_lus", ld_use_stall, 1'b1);
      check("pre_rst_wb_valid", wb_valid[0], 1'b1);
      mon_en = 1'b0;
      #2 rstn = 1'b0;
      #1;
      check("arst_wb_valid", wb_valid, '0);
      check("arst_wb_rf_we", wb_rf_we, '0);
      check("arst_wb_waddr", wb_rf_waddr, '0);
      check("arst_wb_wdata", wb_rf_wdata, '0);
      check("arst_ld_use", ld_use_stall, 1'b0);
      sb.delete();
      model_clear();
      @(negedge clk);
      rstn = 1'b1;
      clr_ex();
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/be_pipe_fwd.md
Name: be_pipe_fwd

Overview:
Parametrised successor to the dual-issue EX→MEM→WB back-end plumbing. Holds the MEM and WB pipeline registers for LANES issue lanes, selects each lane's MEM write-back value from a one-hot source select, and forwards MEM/WB results to every EX source operand. Adds what the fixed dual-lane version lacks: a lane-generic kill mask, a flush input, a working stall, and load-use hazard detection with automatic bubble insertion. Sits between the EX functional units and the register file.

Parameters:
LANES, 2, issue lanes per group; lane 0 is oldest.
XLEN, 32, datapath width.
RA_W, 5, register address width.
NSRC, 2, source operands per lane.
SEL_W, 6, write-back select width, one-hot: bit0 ALU, bit1 LD, bit2 MUL, bit3 MULH, bit4 DIV, bit5 MOD.

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
ex_valid  in  LANES  lane holds a real instruction
ex_rf_we  in  LANES  lane writes RF
ex_rf_waddr  in  LANES*RA_W  destination register
ex_alu_result  in  LANES*XLEN  ALU result
ex_wb_sel  in  LANES*SEL_W  one-hot write-back source
ex_br_kill  in  LANES  lane i mispredicted; kills lanes > i in this group
ex_rf_raddr  in  LANES*NSRC*RA_W  source register addresses
ex_rf_rdata  in  LANES*NSRC*XLEN  RF read data
flush_i  in  1  kill the whole EX group
stall_i  in  1  dcache/divider stall
mem_src_data  in  (SEL_W-1)*XLEN  MEM-stage data for sel bits 1..SEL_W-1, shared by all lanes
ex_rf_rdata_f  out  LANES*NSRC*XLEN  forwarded operands
ld_use_stall  out  1  EX must hold; bubble inserted into MEM
wb_valid  out  LANES  WB lane valid
wb_rf_we  out  LANES  RF write enable
wb_rf_waddr  out  LANES*RA_W  RF write address
wb_rf_wdata  out  LANES*XLEN  RF write data

Behaviour:
- Reset (rstn=0, async): all MEM/WB valid, we, waddr, wdata, and sel registers = 0. Outputs: wb_valid=0, wb_rf_we=0, wb_rf_waddr=0, wb_rf_wdata=0, ld_use_stall=0.
- Lane admission into MEM: kill_j = flush_i | OR(ex_br_kill[0..j-1]). mem_valid_j <= ex_valid[j] & ~kill_j & ~ld_use_stall. mem_we_j <= ex_rf_we[j] & mem_valid_j & (ex_rf_waddr_j != 0). A lane's own ex_br_kill never kills that lane.
- MEM→WB, 1 cycle: wdata_j = OR over k of (sel_j[k] ? src_k), where src_0 = MEM ALU result and src_k = mem_src_data slice k-1. All-zero sel gives 0. At most one lane selects a non-ALU source per group; issue logic guarantees this.
- Latency: EX→WB outputs is 2 cycles when not stalled.
- Stall: stall_i=1 freezes the MEM and WB registers. ex_br_kill, flush_i and ld_use_stall have no effect on state that cycle; upstream holds EX and re-presents flush/kill. Stall dominates every simultaneous event. WB outputs stay asserted while frozen; the repeated RF write is idempotent.
- Forwarding, per EX source s, combinational:
  - raddr==0 → ex_rf_rdata unchanged.
  - Otherwise the first match wins, in this order:
    1. MEM lanes, highest lane index first, with mem_we and matching waddr.
    2. WB lanes, highest lane index first, with wb_rf_we and matching waddr.
    3. ex_rf_rdata.
  - A MEM match forwards the MEM ALU result only.
  - No intra-group forwarding; issue logic guarantees no same-group RAW dependency.
- Load-use: ld_use_stall = 1 when any EX source with ex_valid, raddr!=0, and no kill has its winning match in MEM with sel[0]==0.
  - When ld_use_stall=1 and stall_i=0: MEM loads all-invalid, WB advances, EX is held upstream.
  - The next cycle the dependency resolves from WB.
  - ld_use_stall is combinational and is ignored by this block while stall_i=1.
- Reset mid-operation clears everything immediately. No partial write survives.

Decomposition:
- Package be_pkg holds:
  - WB_SEL_* bit-index localparams.
  - Default LANES/XLEN/RA_W.
  - A typedef for the MEM entry struct {valid, we, waddr, alu_result, wb_sel}.
- Sub-module be_fwd_mux: one source's priority compare across MEM/WB lanes. It outputs forwarded data and a hazard bit, and is instantiated LANES*NSRC times via generate.

Test Plan:
- Back-to-back dependency, all sel=ALU:
  - Cycle0: lane0 writes r5=0x11, ALU. Cycle1: lane1 reads r5 → ex_rf_rdata_f=0x11 (MEM forward).
  - Cycle2: lane0 reads r5 → 0x11 (WB forward). Cycle2: wb_rf_we[0]=1, waddr=5.
- Priority: MEM lane0 and lane1 both write r7 (0xA, 0xB), WB lane1 writes r7=0xC; EX reads r7 → 0xB.
- Load-use: lane1 LD r3 (sel=6'b000010), next group reads r3 → ld_use_stall=1 for one cycle, MEM bubble. With mem_src_data[0]=0xDEAD: next cycle read r3=0xDEAD via WB, ld_use_stall=0.
- Kill/flush, LANES=4:
  - ex_br_kill=4'b0010 with ex_valid=4'b1111 → MEM valid 4'b0011.
  - flush_i=1 → 4'b0000.
  - Writes to r0 → wb_rf_we=0, and a read of r0 returns RF data.
- Stall: stall_i=1 for 3 cycles with wb_rf_waddr=9, wdata=0x55 → outputs constant, new EX group not absorbed. Simultaneous flush_i ignored. Release → pipeline resumes in order.
- Reset: assert rstn=0 mid-stall asynchronously → all wb_* outputs and ld_use_stall go 0 before the next clk edge.
